// File: rtl/arb_grant_bus_mux.sv
// Shared-bus data mux downstream of the 4-way arbiter: forwards beats from the
// granted master into a registered output slot, with turnaround and error tracking.
module arb_grant_bus_mux #(
    parameter int unsigned DW       = 8,
    parameter int unsigned TURN_CYC = 1,
    parameter int unsigned CW       = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          ga,
    input  logic          gb,
    input  logic          gc,
    input  logic          gd,
    input  logic          va,
    input  logic          vb,
    input  logic          vc,
    input  logic          vd,
    input  logic [DW-1:0] da,
    input  logic [DW-1:0] db,
    input  logic [DW-1:0] dc,
    input  logic [DW-1:0] dd,
    output logic          aa,
    output logic          ab,
    output logic          ac,
    output logic          ad,
    output logic [DW-1:0] bus_data,
    output logic          bus_valid,
    output logic [1:0]    bus_owner,
    input  logic          bus_ready,
    output logic [CW-1:0] beat_cnt,
    output logic          err_multi
);

    localparam int unsigned TW = 2;
    localparam logic [TW-1:0] TURN_LOAD = TW'(TURN_CYC - 1);
    localparam logic [CW-1:0] CNT_MAX   = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        TURN = 2'd1,
        XFER = 2'd2
    } state_t;

    state_t        state;
    logic [1:0]    owner;
    logic [TW-1:0] turn_cnt;

    logic [3:0]    g;
    logic [3:0]    v;
    logic          single;
    logic          multi;
    logic [1:0]    idx;
    logic [DW-1:0] d_sel;
    logic          slot_free;
    logic          acc;

    assign g         = {gd, gc, gb, ga};
    assign v         = {vd, vc, vb, va};
    assign slot_free = !bus_valid || bus_ready;

    // Grant decode: exactly one bit set is a usable grant; several bits is a protocol error.
    always_comb begin
        single = (g != 4'd0) && ((g & (g - 4'd1)) == 4'd0);
        multi  = (g != 4'd0) && !single;
        idx    = 2'd0;
        case (g)
            4'b0010: idx = 2'd1;
            4'b0100: idx = 2'd2;
            4'b1000: idx = 2'd3;
            default: idx = 2'd0;
        endcase
    end

    always_comb begin
        d_sel = da;
        case (owner)
            2'd1:    d_sel = db;
            2'd2:    d_sel = dc;
            2'd3:    d_sel = dd;
            default: d_sel = da;
        endcase
    end

    assign acc = (state == XFER) && single && (idx == owner) && v[owner] && slot_free;
    assign aa  = acc && (owner == 2'd0);
    assign ab  = acc && (owner == 2'd1);
    assign ac  = acc && (owner == 2'd2);
    assign ad  = acc && (owner == 2'd3);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            owner     <= 2'd0;
            turn_cnt  <= '0;
            bus_data  <= '0;
            bus_valid <= 1'b0;
            bus_owner <= 2'd0;
            beat_cnt  <= '0;
            err_multi <= 1'b0;
        end else begin
            if (multi) begin
                err_multi <= 1'b1;
            end

            // Output slot: a new beat replaces a draining one, otherwise drain on ready.
            if (acc) begin
                bus_data  <= d_sel;
                bus_valid <= 1'b1;
                bus_owner <= owner;
            end else if (bus_ready) begin
                bus_valid <= 1'b0;
            end

            if (acc && (beat_cnt != CNT_MAX)) begin
                beat_cnt <= beat_cnt + CW'(1);
            end

            case (state)
                IDLE: begin
                    if (single) begin
                        owner    <= idx;
                        beat_cnt <= '0;
                        state    <= XFER;
                    end
                end
                XFER: begin
                    if (!single) begin
                        state <= IDLE;
                    end else if (idx != owner) begin
                        owner    <= idx;
                        beat_cnt <= '0;
                        turn_cnt <= TURN_LOAD;
                        state    <= TURN;
                    end
                end
                TURN: begin
                    if (!single) begin
                        state <= IDLE;
                    end else if (idx != owner) begin
                        owner    <= idx;
                        beat_cnt <= '0;
                        turn_cnt <= TURN_LOAD;
                    end else if (turn_cnt == '0) begin
                        state <= XFER;
                    end else begin
                        turn_cnt <= turn_cnt - TW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
